tuner_ring_sched: RTL and testbench

Round-robin scheduler that shares a single tuner search engine (trigger/peaks handshake) and its ring-select mux among `NUM_CHANNEL` microrings in a multiring row. For each granted ring it triggers one search and captures the returned peak list. It then picks the strongest peak and commits that DAC code as the ring's lock code. It sits between per-ring lock requesters and the search/arbiter PHY, and drives the analog-side ring select.

---
 rtl/tuner_ring_sched.sv | 199 +++++++++++++++++++
 tb/tb_tuner_ring_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tuner_ring_sched.sv
// tuner_ring_sched: round-robin owner of a shared tuner search engine.
// Grants one ring at a time, triggers a search, scans the returned peak list
// for the strongest peak and commits its DAC code as that ring's lock code.
`timescale 1ns/1ps
module tuner_ring_sched #(
  parameter int NUM_CHANNEL   = 2,
  parameter int DAC_WIDTH     = 8,
  parameter int ADC_WIDTH     = 8,
  parameter int NUM_TARGET    = 4,
  parameter int TimeoutCycles = 4096
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_CHANNEL-1:0]                i_req,
  output logic [NUM_CHANNEL-1:0]                o_req_ack,
  output logic [$clog2(NUM_CHANNEL)-1:0]        o_sel_ring,
  output logic                                  o_busy,
  output logic                                  o_search_trig_val,
  input  logic                                  i_search_trig_rdy,
  input  logic                                  i_search_peaks_val,
  output logic                                  o_search_peaks_rdy,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  i_ring_tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  i_pwr_peaks,
  input  logic [$clog2(NUM_TARGET):0]           i_peaks_cnt,
  output logic [NUM_CHANNEL-1:0][DAC_WIDTH-1:0] o_ring_tune_lock,
  output logic [NUM_CHANNEL-1:0]                o_lock_val,
  output logic [NUM_CHANNEL-1:0]                o_err,
  output logic [2:0]                            o_mon_state
);

  localparam int SelW = $clog2(NUM_CHANNEL);
  localparam int IdxW = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;
  localparam int CntW = $clog2(NUM_TARGET) + 1;
  localparam int TmoW = $clog2(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_TARGET - 1);
  localparam logic [SelW-1:0] RingLast = SelW'(NUM_CHANNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRIG   = 3'd1,
    S_WAIT   = 3'd2,
    S_PICK   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  state_e                                state_q;
  logic [SelW-1:0]                       rr_ptr_q;
  logic [SelW-1:0]                       sel_q;
  logic                                  busy_q;
  logic                                  trig_val_q;
  logic                                  peaks_rdy_q;
  logic [NUM_CHANNEL-1:0]                ack_q;
  logic [NUM_CHANNEL-1:0][DAC_WIDTH-1:0] lock_q;
  logic [NUM_CHANNEL-1:0]                lock_val_q;
  logic [NUM_CHANNEL-1:0]                err_q;
  logic [TmoW-1:0]                       tmo_q;
  logic [IdxW-1:0]                       idx_q;
  logic [DAC_WIDTH-1:0]                  best_code_q;
  logic [ADC_WIDTH-1:0]                  best_pwr_q;
  logic                                  have_q;
  logic                                  fail_q;

  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  peak_code_q;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  peak_pwr_q;
  logic [CntW-1:0]                       peak_cnt_q;

  logic [SelW-1:0]                       grant_idx;
  logic                                  grant_found;

  // First requesting ring at or after the round-robin pointer, with wrap.
  always_comb begin
    logic [SelW:0] cand;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      cand = {1'b0, rr_ptr_q} + (SelW+1)'(k);
      if (cand >= (SelW+1)'(NUM_CHANNEL)) cand = cand - (SelW+1)'(NUM_CHANNEL);
      if (!grant_found && i_req[cand[SelW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SelW-1:0];
      end
    end
  end

  // Peak list capture on the peaks handshake.
  // NOTE: the peak buffer carries no reset; PICK only reads it after a capture has filled it.
  always_ff @(posedge i_clk) begin
    if (state_q == S_WAIT && i_search_peaks_val) begin
      peak_code_q <= i_ring_tune_peaks;
      peak_pwr_q  <= i_pwr_peaks;
      peak_cnt_q  <= i_peaks_cnt;
    end
  end

  // Scheduler FSM with registered handshake, status and per-ring lock outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (i_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      trig_val_q  <= 1'b0;
      peaks_rdy_q <= 1'b0;
      ack_q       <= '0;
      lock_q      <= '0;
      lock_val_q  <= '0;
      err_q       <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      best_code_q <= '0;
      best_pwr_q  <= '0;
      have_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            sel_q                 <= grant_idx;
            lock_val_q[grant_idx] <= 1'b0;
            fail_q                <= 1'b0;
            trig_val_q            <= 1'b1;
            busy_q                <= 1'b1;
            state_q               <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (i_search_trig_rdy) begin
            trig_val_q  <= 1'b0;
            peaks_rdy_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (i_search_peaks_val) begin
            peaks_rdy_q <= 1'b0;
            idx_q       <= '0;
            have_q      <= 1'b0;
            best_pwr_q  <= '0;
            best_code_q <= '0;
            state_q     <= S_PICK;
          end else if (tmo_q == TmoLast) begin
            // Engine never answered: flag the ring now and close out without a lock.
            peaks_rdy_q  <= 1'b0;
            fail_q       <= 1'b1;
            err_q[sel_q] <= 1'b1;
            state_q      <= S_COMMIT;
          end
        end
        S_PICK: begin
          // Strictly-greater compare keeps the lowest index on equal power.
          if ((CntW'(idx_q) < peak_cnt_q) &&
              (!have_q || (peak_pwr_q[idx_q] > best_pwr_q))) begin
            have_q      <= 1'b1;
            best_pwr_q  <= peak_pwr_q[idx_q];
            best_code_q <= peak_code_q[idx_q];
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            fail_q  <= (peak_cnt_q == '0);
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (fail_q) begin
            err_q[sel_q]      <= 1'b1;
            lock_val_q[sel_q] <= 1'b0;
          end else begin
            lock_q[sel_q]     <= best_code_q;
            lock_val_q[sel_q] <= 1'b1;
            err_q[sel_q]      <= 1'b0;
          end
          ack_q[sel_q] <= 1'b1;
          rr_ptr_q     <= (sel_q == RingLast) ? '0 : sel_q + 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ack          = ack_q;
  assign o_sel_ring         = sel_q;
  assign o_busy             = busy_q;
  assign o_search_trig_val  = trig_val_q;
  assign o_search_peaks_rdy = peaks_rdy_q;
  assign o_ring_tune_lock   = lock_q;
  assign o_lock_val         = lock_val_q;
  assign o_err              = err_q;
  assign o_mon_state        = state_q;

endmodule

// File: tb/tb_tuner_ring_sched.sv
// Scoreboard bench for tuner_ring_sched: a driver issues lock requests, a
// search-engine responder answers triggers, and a monitor checks each ack
// against a ring/lock model derived from the scheduling and peak-pick rules.
`timescale 1ns/1ps
module tb_tuner_ring_sched;

  localparam int NC = 2;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NT = 4;
  localparam int TO = 16;
  localparam int SW = 1;
  localparam int CW = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NC-1:0]          i_req = '0;
  logic [NC-1:0]          o_req_ack;
  logic [SW-1:0]          o_sel_ring;
  logic                   o_busy;
  logic                   o_search_trig_val;
  logic                   trig_rdy = 1'b0;
  logic                   peaks_val = 1'b0;
  logic                   o_search_peaks_rdy;
  logic [NT-1:0][DW-1:0]  peaks_code = '0;
  logic [NT-1:0][AW-1:0]  peaks_pwr = '0;
  logic [CW-1:0]          peaks_cnt = '0;
  logic [NC-1:0][DW-1:0]  o_ring_tune_lock;
  logic [NC-1:0]          o_lock_val;
  logic [NC-1:0]          o_err;
  logic [2:0]             o_mon_state;

  always #5 clk = ~clk;

  tuner_ring_sched #(
    .NUM_CHANNEL(NC), .DAC_WIDTH(DW), .ADC_WIDTH(AW),
    .NUM_TARGET(NT), .TimeoutCycles(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .o_req_ack(o_req_ack),
    .o_sel_ring(o_sel_ring), .o_busy(o_busy),
    .o_search_trig_val(o_search_trig_val), .i_search_trig_rdy(trig_rdy),
    .i_search_peaks_val(peaks_val), .o_search_peaks_rdy(o_search_peaks_rdy),
    .i_ring_tune_peaks(peaks_code), .i_pwr_peaks(peaks_pwr), .i_peaks_cnt(peaks_cnt),
    .o_ring_tune_lock(o_ring_tune_lock), .o_lock_val(o_lock_val),
    .o_err(o_err), .o_mon_state(o_mon_state)
  );

  typedef struct packed {
    logic [7:0]            trig_wait;
    logic [7:0]            peaks_wait;
    logic                  timeout;
    logic [CW-1:0]         cnt;
    logic [NT-1:0][DW-1:0] code;
    logic [NT-1:0][AW-1:0] pwr;
  } resp_t;

  typedef struct packed {
    logic [SW-1:0]         ring;
    logic [NC-1:0][DW-1:0] lock;
    logic [NC-1:0]         lval;
    logic [NC-1:0]         err;
  } exp_t;

  int    grant_q[$];
  resp_t resp_q[$];
  exp_t  exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what each ring should show after its latest completion.
  logic [NC-1:0][DW-1:0] lock_m = '0;
  logic [NC-1:0]         lval_m = '0;
  logic [NC-1:0]         err_m  = '0;
  int                    rr_m   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int predict_grant(input logic [NC-1:0] req, input int rr);
    for (int k = 0; k < NC; k++)
      if (req[(rr + k) % NC]) return (rr + k) % NC;
    return -1;
  endfunction

  // Strongest peak among the first cnt entries; the earliest one wins a tie.
  function automatic int best_idx(input resp_t r);
    logic [AW-1:0] mx;
    mx = '0;
    if (r.cnt == 0) return -1;
    for (int i = 0; i < int'(r.cnt); i++) if (r.pwr[i] > mx) mx = r.pwr[i];
    for (int i = 0; i < int'(r.cnt); i++) if (r.pwr[i] == mx) return i;
    return -1;
  endfunction

  function automatic exp_t snapshot(input int g);
    exp_t e;
    e.ring = SW'(g);
    e.lock = lock_m;
    e.lval = lval_m;
    e.err  = err_m;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},     o_busy, 0);
    check({tag, "_trig_val"}, o_search_trig_val, 0);
    check({tag, "_peaks_rdy"},o_search_peaks_rdy, 0);
    check({tag, "_sel"},      o_sel_ring, 0);
    check({tag, "_lock"},     o_ring_tune_lock, 0);
    check({tag, "_lock_val"}, o_lock_val, 0);
    check({tag, "_err"},      o_err, 0);
    check({tag, "_ack"},      o_req_ack, 0);
    check({tag, "_state"},    o_mon_state, 0);
  endtask

  // Search-engine responder: answers triggers, delivers peaks or stays silent.
  initial begin
    int    eng;
    int    g_cur, wait_left, peaks_left, wait_cycles, b;
    resp_t cur;
    eng = 0; g_cur = 0; wait_left = 0; peaks_left = 0; wait_cycles = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng = 0; trig_rdy = 1'b0; peaks_val = 1'b0;
      end else begin
        if (eng == 0 && o_search_trig_val) begin
          if (grant_q.size() == 0 || resp_q.size() == 0) begin
            check("unexpected_trigger", o_search_trig_val, 0);
            g_cur = int'(o_sel_ring); cur = '0;
          end else begin
            g_cur = grant_q.pop_front();
            cur   = resp_q.pop_front();
            check("grant_ring", o_sel_ring, g_cur);
          end
          wait_left = int'(cur.trig_wait);
          eng = 1;
        end
        if (eng == 1) begin
          if (trig_rdy) begin
            trig_rdy = 1'b0;
            check("lock_val_cleared_on_grant", o_lock_val[g_cur], 0);
            eng = 2; wait_cycles = 0; peaks_left = int'(cur.peaks_wait);
          end else begin
            check("trig_val_held", o_search_trig_val, 1);
            if (wait_left == 0) trig_rdy = 1'b1;
            else wait_left--;
          end
        end
        if (eng == 2) begin
          if (peaks_val) begin
            peaks_val = 1'b0;
            eng = 0;
          end else if (!o_search_peaks_rdy) begin
            check("timeout_wait_cycles", {cur.timeout, 16'(wait_cycles)}, {1'b1, 16'(TO)});
            check("err_at_timeout", o_err[g_cur], 1);
            err_m[g_cur] = 1'b1; lval_m[g_cur] = 1'b0;
            exp_q.push_back(snapshot(g_cur));
            eng = 0;
          end else begin
            wait_cycles++;
            if (!cur.timeout && peaks_left == 0) begin
              peaks_code = cur.code; peaks_pwr = cur.pwr; peaks_cnt = cur.cnt;
              peaks_val  = 1'b1;
              b = best_idx(cur);
              if (b < 0) begin
                err_m[g_cur] = 1'b1; lval_m[g_cur] = 1'b0;
              end else begin
                lock_m[g_cur] = cur.code[b]; lval_m[g_cur] = 1'b1; err_m[g_cur] = 1'b0;
              end
              exp_q.push_back(snapshot(g_cur));
            end else if (peaks_left > 0) begin
              peaks_left--;
            end
          end
        end
      end
    end
  end

  // Monitor: every ack pops one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_req_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", o_req_ack, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_onehot", o_req_ack, 1 << e.ring);
          check("ack_sel_ring", o_sel_ring, e.ring);
          check("lock_codes", o_ring_tune_lock, e.lock);
          check("lock_val", o_lock_val, e.lval);
          check("err", o_err, e.err);
          check("idle_after_commit", {o_busy, o_mon_state}, 0);
        end
      end
    end
  end

  task automatic do_txn(input logic [NC-1:0] req, input resp_t r, input bit drop_mid,
                        input int exp_lat);
    int g, cyc;
    g = predict_grant(req, rr_m);
    grant_q.push_back(g);
    resp_q.push_back(r);
    rr_m  = (g + 1) % NC;
    i_req = req;
    cyc   = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (o_req_ack != '0) break;
      if (drop_mid && cyc == 3) i_req = '0;
      if (cyc > 300) begin
        check("ack_wait_expired", o_req_ack, 1 << g);
        break;
      end
    end
    if (exp_lat >= 0) check("latency", cyc, exp_lat);
    i_req = '0;
  endtask

  function automatic resp_t zero_resp(input int cnt);
    resp_t r;
    r = '0;
    r.cnt = CW'(cnt);
    for (int i = 0; i < NT; i++) begin
      r.code[i] = DW'($urandom);
      r.pwr[i]  = AW'($urandom_range(0, 7));
    end
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    int    rr_exp[3];
    int    g;
    rr_exp = '{0, 1, 0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Round robin with both rings requesting continuously.
    for (int i = 0; i < 3; i++) begin
      do_txn(2'b11, zero_resp(4), 1'b0, 8);
      check("rr_order", o_sel_ring, rr_exp[i]);
    end

    // Single request from the test plan.
    r = '0; r.cnt = 3'd4;
    r.code = {8'd200, 8'd120, 8'd80, 8'd30};
    r.pwr  = {8'd90, 8'd40, 8'd90, 8'd10};
    do_txn(2'b01, r, 1'b0, 8);
    check("single_lock_code", o_ring_tune_lock[0], 80);
    check("single_ack", o_req_ack, 2'b01);

    // Count boundary: a louder entry beyond cnt must be ignored.
    r = '0; r.cnt = 3'd2;
    r.code = {8'd44, 8'd33, 8'd22, 8'd11};
    r.pwr  = {8'd250, 8'd0, 8'd7, 8'd5};
    do_txn(2'b10, r, 1'b0, 8);
    check("cnt2_lock_code", o_ring_tune_lock[1], 22);

    // Count zero: error, previous code kept, ack still issued.
    do_txn(2'b10, zero_resp(0), 1'b0, 8);
    check("cnt0_err", o_err[1], 1);
    check("cnt0_code_kept", o_ring_tune_lock[1], 22);

    // Timeout: engine never returns peaks.
    r = zero_resp(4); r.timeout = 1'b1;
    do_txn(2'b01, r, 1'b0, 19);
    check("timeout_err", o_err[0], 1);

    // Trigger backpressure of 5 cycles.
    r = zero_resp(4); r.trig_wait = 8'd5;
    do_txn(2'b01, r, 1'b0, 13);

    // Reset in WAIT: abandoned search, no ack, regrant once reset lifts.
    r = zero_resp(4); r.peaks_wait = 8'd10;
    g = predict_grant(2'b01, rr_m);
    grant_q.push_back(g);
    resp_q.push_back(r);
    i_req = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_search_peaks_rdy) break;
    end
    check("reached_wait", o_search_peaks_rdy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midop_reset");
    @(negedge clk);
    rr_m = 0; lock_m = '0; lval_m = '0; err_m = '0;
    grant_q.delete(); resp_q.delete();
    rst = 1'b0;
    do_txn(2'b01, zero_resp(4), 1'b0, 8);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      r = zero_resp($urandom_range(0, NT));
      r.trig_wait  = 8'($urandom_range(0, 3));
      r.peaks_wait = 8'($urandom_range(0, 4));
      r.timeout    = ($urandom_range(0, 7) == 0);
      do_txn(NC'($urandom_range(1, 3)), r, ($urandom_range(0, 3) == 0), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
